// File: rtl/out_sel_scheduler.sv
// out_sel_scheduler: round-robin owner selection for the shared one-hot output lines.
// Produces the 1-based select code for the output decoder (0 = nothing driven).
// Enforces a mandatory idle cycle between grants and an optional maximum hold time.
module out_sel_scheduler #(
   parameter int N_REQ    = 8,
   parameter int SEL_W    = $clog2(N_REQ + 1),
   parameter int MAX_HOLD = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             en_i,
   input  logic [N_REQ-1:0] req_i,
   input  logic             done_i,
   output logic [SEL_W-1:0] sel_o,
   output logic             busy_o,
   output logic             timeout_o
);

   // A zero-width counter is not legal, so an unlimited hold still keeps one bit.
   localparam int CNT_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
   localparam int PTR_W = $clog2(N_REQ);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   state_t           state_q;
   logic [PTR_W-1:0] last_q;
   logic [PTR_W-1:0] owner_q;
   logic [CNT_W-1:0] cnt_q;
   logic [SEL_W-1:0] sel_q;
   logic             busy_q;
   logic             timeout_q;

   logic             win_vld_s;
   logic [PTR_W-1:0] win_idx_s;
   logic             hold_exp_s;
   logic             owner_req_s;

   // Round-robin search: scan from farthest to nearest so the nearest set bit after last_q wins.
   always_comb begin
      logic [PTR_W-1:0] idx_v;
      idx_v     = '0;
      win_vld_s = 1'b0;
      win_idx_s = '0;
      for (int off = N_REQ; off >= 1; off--) begin
         idx_v     = PTR_W'((int'(last_q) + off) % N_REQ);
         win_vld_s = win_vld_s | req_i[idx_v];
         win_idx_s = req_i[idx_v] ? idx_v : win_idx_s;
      end
   end

   // Release qualifiers for the current owner.
   always_comb begin
      hold_exp_s  = (MAX_HOLD != 0) && (cnt_q == CNT_W'(MAX_HOLD - 1));
      owner_req_s = req_i[owner_q];
   end

   // Scheduler FSM with all outputs registered; release always passes through IDLE for one cycle.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= ST_IDLE;
         sel_q     <= '0;
         busy_q    <= 1'b0;
         timeout_q <= 1'b0;
         cnt_q     <= '0;
         last_q    <= PTR_W'(N_REQ - 1);
         owner_q   <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               timeout_q <= 1'b0;
               if (en_i && win_vld_s) begin
                  owner_q <= win_idx_s;
                  sel_q   <= SEL_W'(win_idx_s) + SEL_W'(1);
                  busy_q  <= 1'b1;
                  cnt_q   <= '0;
                  state_q <= ST_GRANT;
               end else begin
                  sel_q   <= '0;
                  busy_q  <= 1'b0;
               end
            end
            ST_GRANT: begin
               if (!en_i || done_i || !owner_req_s) begin
                  // Voluntary or enable-driven release never flags a timeout.
                  sel_q     <= '0;
                  busy_q    <= 1'b0;
                  timeout_q <= 1'b0;
                  last_q    <= owner_q;
                  state_q   <= ST_IDLE;
               end else if (hold_exp_s) begin
                  sel_q     <= '0;
                  busy_q    <= 1'b0;
                  timeout_q <= 1'b1;
                  last_q    <= owner_q;
                  state_q   <= ST_IDLE;
               end else begin
                  cnt_q     <= (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
                  timeout_q <= 1'b0;
               end
            end
            default: begin
               state_q   <= ST_IDLE;
               sel_q     <= '0;
               busy_q    <= 1'b0;
               timeout_q <= 1'b0;
            end
         endcase
      end
   end

   assign sel_o     = sel_q;
   assign busy_o    = busy_q;
   assign timeout_o = timeout_q;

endmodule

// File: tb/tb_out_sel_scheduler.sv
// Testbench for out_sel_scheduler: behavioural reference model feeding a scoreboard queue,
// plus directed checks for the hold limit, wrap-around order and release priority.
module tb_out_sel_scheduler;

   localparam int N = 8;
   localparam int MH = 16;

   logic         clk;
   logic         rst;
   logic         en;
   logic [N-1:0] req;
   logic         done;
   logic [3:0]   sel;
   logic         busy;
   logic         timeout;

   typedef struct packed {
      logic [3:0] sel;
      logic       busy;
      logic       to;
   } exp_t;

   exp_t sb_q[$];

   int n_vec = 0;
   int n_err = 0;

   // Reference model state
   bit m_grant;
   int m_owner;
   int m_last;
   int m_cnt;

   int obs_sel;
   int obs_to;
   int seq[$];

   out_sel_scheduler #(.N_REQ(N), .MAX_HOLD(MH)) dut (
      .clk_i     (clk),
      .rst_i     (rst),
      .en_i      (en),
      .req_i     (req),
      .done_i    (done),
      .sel_o     (sel),
      .busy_o    (busy),
      .timeout_o (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_vec++;
      if (obs != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // Compute the outputs expected after the coming edge from the inputs now applied.
   task automatic model_eval();
      exp_t e;
      int   found;
      int   i;
      e = '0;
      if (rst) begin
         m_grant = 1'b0; m_cnt = 0; m_last = N - 1; m_owner = 0;
      end else if (!m_grant) begin
         found = -1;
         if (en) begin
            for (int k = 1; k <= N; k++) begin
               i = (m_last + k) % N;
               if (found < 0 && req[i]) found = i;
            end
         end
         if (found >= 0) begin
            m_grant = 1'b1; m_owner = found; m_cnt = 0;
            e.sel = 4'(found + 1); e.busy = 1'b1;
         end
      end else begin
         if (!en || done || !req[m_owner]) begin
            m_grant = 1'b0; m_last = m_owner;
         end else if (m_cnt == MH - 1) begin
            m_grant = 1'b0; m_last = m_owner; e.to = 1'b1;
         end else begin
            m_cnt++;
            e.sel = 4'(m_owner + 1); e.busy = 1'b1;
         end
      end
      sb_q.push_back(e);
   endtask

   task automatic step();
      exp_t e;
      model_eval();
      @(posedge clk);
      #1;
      obs_sel = int'(sel);
      obs_to  = int'(timeout);
      if (sb_q.size() == 0) begin
         chk("sb_empty", 1, 0);
      end else begin
         e = sb_q.pop_front();
         chk("sel", int'(sel), int'(e.sel));
         chk("busy", int'(busy), int'(e.busy));
         chk("timeout", int'(timeout), int'(e.to));
      end
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; req = '0; done = 1'b0;
      step(); step();
      chk("rst_sel", obs_sel, 0);
      chk("rst_busy", int'(busy), 0);

      // 1: first grant one cycle after request, requester 0 first
      rst = 1'b0; en = 1'b1; req = 8'h81;
      step();
      chk("t1_sel", obs_sel, 1);
      chk("t1_busy", int'(busy), 1);

      // 2: hold limit of 16 cycles, then requester 7 next
      for (int s = 1; s < 20; s++) begin
         step();
         if (s == 15) chk("t2_last_hold", obs_sel, 1);
         if (s == 16) begin
            chk("t2_gap_sel", obs_sel, 0);
            chk("t2_timeout", obs_to, 1);
         end
         if (s == 17) begin
            chk("t2_next_sel", obs_sel, 8);
            chk("t2_to_clear", obs_to, 0);
         end
      end

      // 3: all requesting, done one cycle into each grant, wrap-around order
      req = 8'hFF; done = 1'b1;
      step();
      chk("t3_release7", obs_sel, 0);
      seq.delete();
      for (int g = 0; g < 9; g++) begin
         done = 1'b0; step(); seq.push_back(obs_sel);
         done = 1'b1; step(); seq.push_back(obs_sel);
      end
      for (int j = 0; j < 18; j++)
         chk("t3_seq", seq[j], (j % 2 == 0) ? ((j / 2) % N) + 1 : 0);

      // 4: done coincides with the final hold cycle -> no timeout pulse
      done = 1'b0; req = 8'h08;
      step();
      chk("t4_sel", obs_sel, 4);
      for (int s = 0; s < 15; s++) step();
      chk("t4_still", obs_sel, 4);
      done = 1'b1;
      step();
      chk("t4_sel0", obs_sel, 0);
      chk("t4_no_to", obs_to, 0);

      // 5: enable drop mid-grant, then no grants while disabled
      done = 1'b0;
      step();
      chk("t5_sel", obs_sel, 4);
      step();
      en = 1'b0;
      step();
      chk("t5_drop", obs_sel, 0);
      chk("t5_no_to", obs_to, 0);
      req = 8'hFF;
      for (int s = 0; s < 10; s++) begin
         step();
         chk("t5_idle", obs_sel, 0);
      end

      // 6: reset during a grant restores requester 0 priority
      en = 1'b1; req = 8'h10;
      step();
      chk("t6_sel5", obs_sel, 5);
      step(); step();
      rst = 1'b1;
      step();
      chk("t6_rst_sel", obs_sel, 0);
      chk("t6_rst_busy", int'(busy), 0);
      rst = 1'b0; req = 8'hFF;
      step();
      chk("t6_after", obs_sel, 1);

      // Random traffic checked purely by the scoreboard
      for (int s = 0; s < 600; s++) begin
         rst  = ($urandom_range(0, 99) == 0);
         en   = ($urandom_range(0, 11) != 0);
         done = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 3) == 0) req = 8'($urandom_range(0, 255));
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
